demux_1to2_stream: RTL and testbench
====================================

DEMUX_1TO2_STREAM -- requirements
Module: demux_1to2_stream

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of the data path.
REQ-002 Clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Reset_n  input  1  reset, asynchronous and active-low.
REQ-004 C  input  DATA_WIDTH  input data word.
REQ-005 Select  input  1  destination of the input word; 0 routes to A, 1 routes to B.
REQ-006 In_Valid  input  1  C and Select valid this cycle.
REQ-007 In_Ready  output  1  block accepts C/Select this cycle.
REQ-008 A  output  DATA_WIDTH  output word for destination 0.
REQ-009 A_Valid  output  1  A holds a word awaiting transfer.
REQ-010 A_Ready  input  1  consumer A accepts this cycle.
REQ-011 B, B_Valid, B_Ready SHALL mirror REQ-008 to REQ-010 for destination 1.

Function
REQ-012 An input handshake SHALL occur on a rising edge where In_Valid=1 and In_Ready=1; an output handshake SHALL occur where X_Valid=1 and X_Ready=1.
REQ-013 The block SHALL hold one entry: data register, destination bit and a two-state FSM, EMPTY and FULL.
REQ-014 EMPTY: In_Ready=1, A_Valid=B_Valid=0; on an input handshake, load C and Select and go to FULL.
REQ-015 FULL: A_Valid = (dest==0), B_Valid = (dest==1); exactly one valid SHALL be high.
REQ-016 FULL, output handshake, In_Valid=0: go to EMPTY.
REQ-017 FULL, output handshake, In_Valid=1 in the same cycle: reload the entry and stay FULL; back-to-back words SHALL flow at one word per cycle.
REQ-018 FULL, no output handshake: hold the entry unchanged, with In_Ready=0.
REQ-019 In_Ready SHALL be combinational: (state==EMPTY) OR (ready of the currently selected output); the ready of the unselected output SHALL have no effect.
REQ-020 Latency SHALL be one cycle: a word accepted at edge N presents valid after edge N.
REQ-021 The selected output SHALL drive the held data; the unselected output SHALL drive all zeros.
REQ-022 X_Valid, once high, SHALL stay high with stable data until its handshake.
REQ-023 Select and C SHALL be sampled only on an input handshake; changes at other times SHALL be ignored.

Reset
REQ-024 When Reset_n=0, the state SHALL go to EMPTY immediately, asynchronously.
REQ-025 Reset values SHALL be: A=0, B=0, A_Valid=0, B_Valid=0, In_Ready=1, data=0, dest=0.
REQ-026 Reset asserted while FULL SHALL discard the held word, with no output handshake reported.
REQ-027 Reset deassertion SHALL take effect at the next rising edge of Clk.

Configuration
REQ-028 Macro DEMUX_STATS_EN defined SHALL add outputs Count_A and Count_B (16 bits each), which increment on every A and B output handshake respectively and saturate at 16'hFFFF.
REQ-029 Under DEMUX_STATS_EN, the counters SHALL reset to 0 with Reset_n.
REQ-030 Without DEMUX_STATS_EN, the counter ports and logic SHALL be absent, with datapath behaviour identical.

Verification
REQ-031 After reset, with A_Ready=B_Ready=1: drive C=8'h5A, Select=0, In_Valid=1 for one cycle -> next cycle A=8'h5A, A_Valid=1, B=0, B_Valid=0; following cycle EMPTY.
REQ-032 Streaming: send 8'h01/S=1, 8'h02/S=0, 8'h03/S=1 on consecutive cycles, both readies held 1 -> B gets 01 then 03, A gets 02, one word per cycle, In_Ready never 0.
REQ-033 Backpressure: send 8'hC3/S=1 with B_Ready=0 and A_Ready=1 for 3 cycles -> B_Valid=1 and B=8'hC3 held, In_Ready=0, a new C/Select ignored; B_Ready=1 -> transfer and In_Ready=1 the same cycle.
REQ-034 Reset mid-operation: FULL with 8'hAA held and B_Ready=0, pull Reset_n low between edges -> B_Valid=0, B=0 and In_Ready=1 without a clock edge.
REQ-035 With DEMUX_STATS_EN defined, perform 5 A and 2 B output handshakes -> Count_A=5, Count_B=2; preload Count_A=16'hFFFE plus 3 A handshakes -> Count_A=16'hFFFF.

Source files
------------

// File: rtl/demux_1to2_stream.sv
// demux_1to2_stream: one-entry stream demultiplexer routing each input word to
// output A (Select=0) or output B (Select=1) with valid/ready handshakes.
// A single holding register gives one cycle of latency and still sustains one
// word per cycle, because the entry may be reloaded in the same cycle it drains.
// Optional feature: define DEMUX_STATS_EN to add saturating 16-bit handshake
// counters Count_A / Count_B.
`timescale 1ns/1ps

module demux_1to2_stream #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic [DATA_WIDTH-1:0] C,
    input  logic                  Select,
    input  logic                  In_Valid,
    output logic                  In_Ready,
    output logic [DATA_WIDTH-1:0] A,
    output logic                  A_Valid,
    input  logic                  A_Ready,
    output logic [DATA_WIDTH-1:0] B,
    output logic                  B_Valid,
    input  logic                  B_Ready
`ifdef DEMUX_STATS_EN
    ,
    output logic [15:0]           Count_A,
    output logic [15:0]           Count_B
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;
    logic                  dest_q,  dest_d;

    logic in_hs;
    logic a_hs;
    logic b_hs;
    logic out_hs;

    // Handshake decode; readiness only looks at the output the held word targets.
    always_comb begin
        A_Valid  = (state_q == FULL) && !dest_q;
        B_Valid  = (state_q == FULL) &&  dest_q;
        a_hs     = A_Valid && A_Ready;
        b_hs     = B_Valid && B_Ready;
        out_hs   = a_hs || b_hs;
        In_Ready = (state_q == EMPTY) || (dest_q ? B_Ready : A_Ready);
        in_hs    = In_Valid && In_Ready;
    end

    // Output data: the selected port shows the held word, the other stays zero.
    always_comb begin
        A = A_Valid ? data_q : '0;
        B = B_Valid ? data_q : '0;
    end

    // Next-state logic; the entry is only written on an accepted input word.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        dest_d  = dest_q;
        unique case (state_q)
            EMPTY: begin
                if (in_hs) begin
                    data_d  = C;
                    dest_d  = Select;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (out_hs) begin
                    if (in_hs) begin
                        data_d  = C;
                        dest_d  = Select;
                        state_d = FULL;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Entry registers; reset empties the block and discards any held word.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            dest_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            dest_q  <= dest_d;
        end
    end

`ifdef DEMUX_STATS_EN
    logic [15:0] cnt_a_q, cnt_a_d;
    logic [15:0] cnt_b_q, cnt_b_d;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Counter next-state: one step per completed output handshake.
    always_comb begin
        cnt_a_d = a_hs ? sat_inc(cnt_a_q) : cnt_a_q;
        cnt_b_d = b_hs ? sat_inc(cnt_b_q) : cnt_b_q;
    end

    // Counter registers, cleared together with the datapath.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    assign Count_A = cnt_a_q;
    assign Count_B = cnt_b_q;
`endif

endmodule

// File: tb/tb_demux_1to2_stream.sv
// Self-checking bench for demux_1to2_stream. A queue of at most one entry
// models the block: the head drives the outputs, it leaves on its consumer's
// ready, and a new word is accepted when the queue is empty or being drained.
// Define DEMUX_STATS_EN to also exercise the handshake counters.
`timescale 1ns/1ps

module tb_demux_1to2_stream;

    logic       Clk;
    logic       Reset_n;
    logic [7:0] C;
    logic       Select;
    logic       In_Valid;
    logic       In_Ready;
    logic [7:0] A;
    logic       A_Valid;
    logic       A_Ready;
    logic [7:0] B;
    logic       B_Valid;
    logic       B_Ready;
`ifdef DEMUX_STATS_EN
    logic [15:0] Count_A;
    logic [15:0] Count_B;
`endif

    demux_1to2_stream #(.DATA_WIDTH(8)) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .C        (C),
        .Select   (Select),
        .In_Valid (In_Valid),
        .In_Ready (In_Ready),
        .A        (A),
        .A_Valid  (A_Valid),
        .A_Ready  (A_Ready),
        .B        (B),
        .B_Valid  (B_Valid),
        .B_Ready  (B_Ready)
`ifdef DEMUX_STATS_EN
        ,
        .Count_A  (Count_A),
        .Count_B  (Count_B)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [7:0] d;
        logic       s;
    } ent_t;

    ent_t        mq[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned m_cnt_a = 0;
    int unsigned m_cnt_b = 0;
    int          a_seen = 0;
    int          b_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: compare all outputs against the model before the edge,
    // then advance the model across the edge. Inputs must already be set.
    task automatic cycle(input string tag);
        logic       e_av, e_bv, e_rdy, pop;
        logic [7:0] e_a, e_b;
        @(negedge Clk);
        e_av  = (mq.size() == 1) && !mq[0].s;
        e_bv  = (mq.size() == 1) &&  mq[0].s;
        e_a   = e_av ? mq[0].d : 8'h00;
        e_b   = e_bv ? mq[0].d : 8'h00;
        pop   = (e_av && A_Ready) || (e_bv && B_Ready);
        e_rdy = (mq.size() == 0) || pop;
        chk({tag, ".A_Valid"},  32'(A_Valid),  32'(e_av));
        chk({tag, ".B_Valid"},  32'(B_Valid),  32'(e_bv));
        chk({tag, ".A"},        32'(A),        32'(e_a));
        chk({tag, ".B"},        32'(B),        32'(e_b));
        chk({tag, ".In_Ready"}, 32'(In_Ready), 32'(e_rdy));
        @(posedge Clk);
        if (pop) begin
            if (e_av) begin
                a_seen++;
                if (m_cnt_a < 32'hFFFF) m_cnt_a++;
            end else begin
                b_seen++;
                if (m_cnt_b < 32'hFFFF) m_cnt_b++;
            end
            void'(mq.pop_front());
        end
        if (In_Valid && e_rdy) mq.push_back('{d: C, s: Select});
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic s,
                         input logic ar, input logic br);
        In_Valid = v;
        C        = d;
        Select   = s;
        A_Ready  = ar;
        B_Ready  = br;
    endtask

    initial begin
        // Reset state
        Reset_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        #12;
        chk("rst.A",        32'(A),        32'h0);
        chk("rst.B",        32'(B),        32'h0);
        chk("rst.A_Valid",  32'(A_Valid),  32'h0);
        chk("rst.B_Valid",  32'(B_Valid),  32'h0);
        chk("rst.In_Ready", 32'(In_Ready), 32'h1);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;

        // Single word to A, then empty again
        drive(1'b1, 8'h5A, 1'b0, 1'b1, 1'b1);
        cycle("w5a.load");
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        chk("w5a.A",       32'(A),       32'h5A);
        chk("w5a.A_Valid", 32'(A_Valid), 32'h1);
        chk("w5a.B",       32'(B),       32'h0);
        chk("w5a.B_Valid", 32'(B_Valid), 32'h0);
        cycle("w5a.drain");
        chk("w5a.empty", 32'(A_Valid | B_Valid), 32'h0);

        // Streaming: B=01, A=02, B=03 back-to-back
        drive(1'b1, 8'h01, 1'b1, 1'b1, 1'b1);
        cycle("str.1");
        drive(1'b1, 8'h02, 1'b0, 1'b1, 1'b1);
        chk("str.B01", 32'(B), 32'h01);
        cycle("str.2");
        drive(1'b1, 8'h03, 1'b1, 1'b1, 1'b1);
        chk("str.A02", 32'(A), 32'h02);
        cycle("str.3");
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        chk("str.B03", 32'(B), 32'h03);
        cycle("str.4");

        // Backpressure on B; unselected A_Ready must not matter and a new
        // word offered meanwhile must be ignored
        drive(1'b1, 8'hC3, 1'b1, 1'b1, 1'b0);
        cycle("bp.load");
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
            cycle("bp.hold");
            chk("bp.B", 32'(B), 32'hC3);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        cycle("bp.release");
        chk("bp.empty", 32'(B_Valid), 32'h0);

        // Asynchronous reset while FULL
        drive(1'b1, 8'hAA, 1'b1, 1'b1, 1'b0);
        cycle("ar.load");
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("ar.held", 32'(B), 32'hAA);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("ar.B_Valid",  32'(B_Valid),  32'h0);
        chk("ar.B",        32'(B),        32'h0);
        chk("ar.In_Ready", 32'(In_Ready), 32'h1);
        mq.delete();
        m_cnt_a = 0;
        m_cnt_b = 0;
        #2;
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        cycle("ar.after");

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
            cycle("rnd");
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        cycle("rnd.flush");
        chk("rnd.a_traffic", 32'(a_seen > 20), 32'h1);
        chk("rnd.b_traffic", 32'(b_seen > 20), 32'h1);

`ifdef DEMUX_STATS_EN
        // Counters: 5 A and 2 B handshakes after a fresh reset
        Reset_n = 1'b0;
        #2;
        mq.delete();
        m_cnt_a = 0;
        m_cnt_b = 0;
        chk("st.rst", 32'({Count_A, Count_B}), 32'h0);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 8'(i + 1), (i == 2 || i == 5), 1'b1, 1'b1);
            cycle("st.run");
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        cycle("st.drain");
        chk("st.Count_A", 32'(Count_A), 32'd5);
        chk("st.Count_B", 32'(Count_B), 32'd2);

        // Saturation from a preloaded value
        dut.cnt_a_q = 16'hFFFE;
        m_cnt_a = 32'hFFFE;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h40, 1'b0, 1'b1, 1'b1);
            cycle("sat.run");
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        cycle("sat.drain");
        chk("sat.Count_A", 32'(Count_A), 32'hFFFF);
        chk("sat.model",   32'(Count_A), m_cnt_a);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
